// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter; grant registered (1 cycle), ACK/ERR/read data combinational.
// Grant held for the whole CYC tenure; hung strobes aborted by a watchdog ERR after TIMEOUT cycles.
module wb_arbiter2 #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_CYC,
    input  logic        m0_STB,
    input  logic        m0_WE,
    input  logic [13:0] m0_ADR,
    input  logic [31:0] m0_DAT_MOSI,
    input  logic [3:0]  m0_SEL,
    output logic        m0_ACK,
    output logic        m0_ERR,
    output logic [31:0] m0_DAT_MISO,
    input  logic        m1_CYC,
    input  logic        m1_STB,
    input  logic        m1_WE,
    input  logic [13:0] m1_ADR,
    input  logic [31:0] m1_DAT_MOSI,
    input  logic [3:0]  m1_SEL,
    output logic        m1_ACK,
    output logic        m1_ERR,
    output logic [31:0] m1_DAT_MISO,
    output logic        s_CYC,
    output logic        s_STB,
    output logic        s_WE,
    output logic [13:0] s_ADR,
    output logic [31:0] s_DAT_MOSI,
    output logic [3:0]  s_SEL,
    input  logic        s_ACK,
    input  logic [31:0] s_DAT_MISO,
    output logic [1:0]  gnt,
    output logic        timeout_stb
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            last;
    logic [WD_W-1:0] wd_cnt;
    logic            abort;
    logic            err_q;
    logic            g_stb;
    logic            grant_chg;
    logic            cnt_cond;
    logic            fire;

    // On a tie from IDLE the master that did not hold the bus last wins.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (m0_CYC && m1_CYC) state_nxt = last ? G0 : G1;
                else if (m0_CYC)      state_nxt = G0;
                else if (m1_CYC)      state_nxt = G1;
            end
            G0: begin
                if (!m0_CYC) state_nxt = m1_CYC ? G1 : IDLE;
            end
            G1: begin
                if (!m1_CYC) state_nxt = m0_CYC ? G0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        g_stb = 1'b0;
        if (state == G0) g_stb = m0_STB;
        if (state == G1) g_stb = m1_STB;
    end

    assign grant_chg = (state_nxt != state);
    assign cnt_cond  = g_stb && !s_ACK && !abort && (TIMEOUT != 0);
    assign fire      = cnt_cond && (wd_cnt == WD_LAST) && !grant_chg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            last   <= 1'b1;
            wd_cnt <= '0;
            abort  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_chg && state_nxt == G0) last <= 1'b0;
            if (grant_chg && state_nxt == G1) last <= 1'b1;
            err_q <= fire;
            if (fire) begin
                abort  <= 1'b1;
                wd_cnt <= '0;
            end else begin
                if (abort && (!g_stb || grant_chg)) abort <= 1'b0;
                if (grant_chg || !g_stb || s_ACK) wd_cnt <= '0;
                else if (cnt_cond)                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    // Slave side and responses follow the registered grant; abort masks STB and ACK.
    always_comb begin
        s_CYC      = 1'b0;
        s_STB      = 1'b0;
        s_WE       = 1'b0;
        s_ADR      = '0;
        s_DAT_MOSI = '0;
        s_SEL      = '0;
        m0_ACK     = 1'b0;
        m1_ACK     = 1'b0;
        m0_ERR     = 1'b0;
        m1_ERR     = 1'b0;
        gnt        = 2'b00;
        unique case (state)
            G0: begin
                s_CYC      = m0_CYC;
                s_STB      = m0_STB && !abort;
                s_WE       = m0_WE;
                s_ADR      = m0_ADR;
                s_DAT_MOSI = m0_DAT_MOSI;
                s_SEL      = m0_SEL;
                m0_ACK     = s_ACK && m0_STB && !abort;
                m0_ERR     = err_q;
                gnt        = 2'b01;
            end
            G1: begin
                s_CYC      = m1_CYC;
                s_STB      = m1_STB && !abort;
                s_WE       = m1_WE;
                s_ADR      = m1_ADR;
                s_DAT_MOSI = m1_DAT_MOSI;
                s_SEL      = m1_SEL;
                m1_ACK     = s_ACK && m1_STB && !abort;
                m1_ERR     = err_q;
                gnt        = 2'b10;
            end
            default: ;
        endcase
    end

    assign m0_DAT_MISO = s_DAT_MISO;
    assign m1_DAT_MISO = s_DAT_MISO;
    assign timeout_stb = err_q;

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master round-robin arbiter for the 14-bit-address / 32-bit-data Wishbone classic bus driven by the CPU-controlled bridge. It lets the external bridge master (m0) and an on-chip engine (m1) share one slave port. It holds each grant for the whole CYC tenure and aborts hung strobes with a watchdog-generated ERR.

## Interface
Parameters:
- TIMEOUT, 255: number of unacknowledged strobe cycles before an abort; 0 disables the watchdog. The counter width is the minimum needed to hold TIMEOUT.

Ports:
- clk  in  1  bus clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mN_CYC, mN_STB, mN_WE  in  1 each  master N cycle, strobe and write enable (N = 0, 1).
- mN_ADR  in  14  master N word address.
- mN_DAT_MOSI  in  32  master N write data.
- mN_SEL  in  4  master N byte select.
- mN_ACK  out  1  acknowledge to master N.
- mN_ERR  out  1  watchdog abort to master N.
- mN_DAT_MISO  out  32  read data, broadcast from s_DAT_MISO to both masters.
- s_CYC, s_STB, s_WE  out  1 each  slave-side cycle, strobe and write enable.
- s_ADR  out  14  slave-side address.
- s_DAT_MOSI  out  32  slave-side write data.
- s_SEL  out  4  slave-side byte select.
- s_ACK  in  1  slave acknowledge.
- s_DAT_MISO  in  32  slave read data.
- gnt  out  2  one-hot current grant; 00 when idle.
- timeout_stb  out  1  one-cycle pulse on every abort.

## Operation
- FSM states: IDLE, G0, G1. Registers: state, last (the index of the most recently granted master), wd_cnt, abort, err_q.
- Reset values: state=IDLE, last=1 (so m0 wins the first tie), wd_cnt=0, abort=0, err_q=0. All outputs are 0 in reset, except mN_DAT_MISO, which always equals s_DAT_MISO.
- Transitions from IDLE:
  - Only one master has CYC=1: grant that master.
  - Both have CYC=1: grant the master that is not `last`.
  - Neither: stay in IDLE.
- Transitions from Gn:
  - mn_CYC=1: stay in Gn.
  - mn_CYC=0 and the other master has CYC=1: go directly to that master's grant state (no idle cycle).
  - Otherwise: go to IDLE.
  - On every entry to a grant state, `last` takes the newly granted index.
- Slave-side muxing (combinational from state):
  - In Gn: s_CYC=mn_CYC, s_STB=mn_STB & ~abort, and s_WE/ADR/DAT_MOSI/SEL are taken from mn.
  - In IDLE: all slave-side outputs are 0.
- ACK routing: mn_ACK = (state==Gn) & s_ACK & mn_STB & ~abort. The non-granted master never sees ACK or ERR.
- Watchdog counting:
  - wd_cnt increments on each cycle where the granted master has STB=1, s_ACK=0 and abort=0.
  - wd_cnt clears on s_ACK, when the granted STB is 0, and on any grant change.
- Watchdog abort: on the edge where wd_cnt==TIMEOUT-1 and the count condition still holds:
  - abort<=1, err_q<=1 for exactly one cycle, wd_cnt<=0.
  - mn_ERR = err_q gated by the grant.
  - timeout_stb = err_q.
- abort is held until the granted master drops STB or the grant changes, then clears on the next edge. While abort=1, s_STB is masked and s_ACK is ignored.
- Arithmetic: wd_cnt never wraps. With TIMEOUT=0, wd_cnt stays 0 and ERR never fires.

## Timing
- Grant latency: CYC rising at edge k gives gnt and s_CYC high from cycle k+1, because the grant is registered. The first strobe reaches the slave in cycle k+1.
- ACK and read data pass through combinationally, adding no latency to the slave's response.
- Release: s_CYC falls in the same cycle the granted master drops CYC. The handover to a waiting master becomes visible one cycle later.
- Simultaneous release and request: the current master drops CYC in the same cycle the other raises it. The other master is granted at the next edge.
- Abort timing: ERR is high in the cycle after the TIMEOUT-th consecutive unacknowledged strobe cycle. A late s_ACK arriving in that same cycle is ignored.
- Reset mid-transfer: rst asserted while granted forces IDLE immediately (asynchronously). s_CYC, s_STB, gnt and ERR drop without waiting for a clock.

## Test plan
- Single master: m0 raises CYC/STB with ADR=14'h0123 and write data 32'hDEADBEEF; slave ACKs after 2 cycles -> gnt=01 from the next cycle, s_ADR=14'h0123, m0_ACK for 1 cycle, m1_ACK stays 0.
- Tie after reset: both masters raise CYC in the same cycle -> m0 granted first. Then m0 drops CYC while m1 holds it -> gnt goes 01 -> 10 on the next edge with no IDLE cycle.
- Round-robin fairness: both masters continuously re-request 4 single-beat cycles each -> grants alternate 0,1,0,1. Neither master is starved.
- Watchdog: TIMEOUT=8, m1 strobes a read and the slave never ACKs -> m1_ERR and timeout_stb pulse once, 9 cycles after STB rose. s_STB is 0 after that until m1 drops STB. An ACK injected during abort does not reach m1.
- Async reset mid-read: rst pulsed between clock edges while gnt=10 -> s_CYC, gnt and m1_ACK go to 0 before the next edge. After rst release, an m0/m1 tie grants m0.
